// File: rtl/mips_dbg_pkg.sv
// Shared debugger definitions: command codes, run-controller state encoding,
// and the default HALT instruction encoding.
package mips_dbg_pkg;

  localparam logic [2:0] CMD_LOAD  = 3'd1;
  localparam logic [2:0] CMD_RUN   = 3'd2;
  localparam logic [2:0] CMD_STEP  = 3'd3;
  localparam logic [2:0] CMD_ABORT = 3'd4;

  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

  // Encoding is exported on o_state for debugger status reporting.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_CLR       = 3'd2,
    S_RUN       = 3'd3,
    S_STEP_WAIT = 3'd4,
    S_STEP      = 3'd5,
    S_DRAIN     = 3'd6,
    S_DUMP      = 3'd7
  } run_state_t;

endpackage

// File: rtl/pipeline_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module sat_counter #(
  parameter int CNT_W = 32
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (en_i && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_run_controller.sv
// Run/step/halt sequencer for the debugger-attached MIPS pipeline; the core advances only on o_pipe_en.
// Optional watchdog enabled by defining PIPE_WATCHDOG_EN.
module pipeline_run_controller
  import mips_dbg_pkg::*;
#(
  parameter int              SIZE         = 32,
  parameter logic [SIZE-1:0] HALT_INSTR   = SIZE'(HALT_INSTR_DEF),
  parameter int              DRAIN_CYCLES = 4,
  parameter int              CNT_W        = 32,
  parameter int              WDOG_CYCLES  = 4096
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  input  logic [2:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_load_done,
  input  logic [SIZE-1:0]  i_ifid_instr,
  input  logic             i_dump_done,
  output logic             o_pipe_en,
  output logic             o_core_rst,
  output logic             o_imem_wsel,
  output logic             o_dump_req,
  output logic             o_halted,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [2:0]       o_state
);

  localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

`ifdef PIPE_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  run_state_t    state_q, state_d;
  logic          step_mode_q, step_mode_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          halted_q, halted_d;
  logic          timeout_q, timeout_d;
  logic          dump_first_q;
  logic          cmd_go, halt_seen, wdog_hit;

  assign cmd_go    = i_cmd_valid & o_cmd_ready;
  assign halt_seen = (i_ifid_instr == HALT_INSTR);
  // Fires on the pipe_en cycle whose edge brings the count to WDOG_CYCLES.
  assign wdog_hit  = WDOG_ON && (o_cycle_cnt == CNT_W'(WDOG_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    drain_d     = drain_q;
    halted_d    = halted_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE: if (cmd_go) begin
        case (i_cmd)
          CMD_LOAD: begin state_d = S_LOAD; halted_d = 1'b0; end
          CMD_RUN:  begin state_d = S_CLR;  step_mode_d = 1'b0; end
          CMD_STEP: begin state_d = S_CLR;  step_mode_d = 1'b1; end
          default:  ;
        endcase
      end
      S_LOAD: if (i_load_done) state_d = S_IDLE;
      S_CLR: begin
        halted_d  = 1'b0;
        timeout_d = 1'b0;
        state_d   = step_mode_q ? S_STEP_WAIT : S_RUN;
      end
      // HALT beats both the watchdog and an abort arriving in the same cycle.
      S_RUN: begin
        if (halt_seen) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LAST;
        end else if (wdog_hit) begin
          timeout_d = 1'b1;
          state_d   = S_DUMP;
        end else if (i_cmd_valid && i_cmd == CMD_ABORT) begin
          state_d = S_DUMP;
        end
      end
      S_STEP_WAIT: begin
        if (halt_seen) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LAST;
        end else if (cmd_go && i_cmd == CMD_STEP) begin
          state_d = S_STEP;
        end else if (cmd_go && i_cmd == CMD_ABORT) begin
          state_d     = S_DUMP;
          step_mode_d = 1'b0;  // abort ends the stepping session
        end
      end
      S_STEP:  state_d = S_DUMP;
      S_DRAIN: begin
        if (drain_q == '0) begin
          halted_d = 1'b1;
          state_d  = S_DUMP;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      S_DUMP: if (i_dump_done) state_d = (step_mode_q && !halted_q) ? S_STEP_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      step_mode_q  <= 1'b0;
      drain_q      <= '0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      dump_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_mode_q  <= step_mode_d;
      drain_q      <= drain_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      dump_first_q <= (state_d == S_DUMP) && (state_q != S_DUMP);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr_i (state_q == S_CLR),
    .en_i  (o_pipe_en),
    .cnt_o (o_cycle_cnt)
  );

  assign o_pipe_en   = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
  assign o_core_rst  = (state_q == S_CLR);
  assign o_imem_wsel = (state_q == S_LOAD);
  assign o_cmd_ready = ((state_q == S_IDLE) || (state_q == S_STEP_WAIT)) && !i_rst;
  assign o_dump_req  = (state_q == S_DUMP) && dump_first_q;
  assign o_halted    = halted_q;
  assign o_timeout   = timeout_q;
  assign o_state     = state_q;

endmodule
